// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, reset PC, NOP encoding, PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    DROP     = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and an idle cycle inserts a bubble.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
      instr_q    <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (stall_i) begin
      valid_q <= valid_q;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
      instr_q    <= instr_i;
    end else begin
      // bubble keeps the last PC pair so decode still sees a sane address
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;

endmodule

// File: rtl/fetch_pc_ifid.sv
// Fetch stage: PC register, variable-latency imem request FSM with a one-entry skid buffer,
// redirect tracking while a request is in flight, and the IF/ID register.
module fetch_pc_ifid
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_q, redir_d;
  logic [31:0]  skid_q, skid_d;
  logic         deliver;
  logic [31:0]  deliver_instr;

  assign pc_plus4  = pc_q + PC_INC;
  assign imem_addr = pc_q;
  // reset gates the request combinationally so nothing is issued while rst is high
  assign imem_req  = !rst && (state_q != BUFFERED);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_d       = redir_q;
    skid_d        = skid_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (flush) begin
            pc_d = next_pc;
          end else if (stall) begin
            skid_d  = imem_rdata;
            state_d = BUFFERED;
          end else begin
            deliver = 1'b1;
            pc_d    = next_pc;
          end
        end else if (flush) begin
          redir_d = next_pc;
          state_d = DROP;
        end
      end
      BUFFERED: begin
        if (flush) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = skid_q;
          pc_d          = next_pc;
          state_d       = FETCH;
        end
      end
      DROP: begin
        // the in-flight request must finish at the old address before redirecting
        if (flush) redir_d = next_pc;
        if (imem_ready) begin
          pc_d    = flush ? next_pc : redir_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      skid_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      skid_q  <= skid_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .stall_i    (stall),
    .load_i     (deliver),
    .instr_i    (deliver_instr),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .valid_o    (ifid_valid),
    .pc_o       (ifid_pc),
    .pc_plus4_o (ifid_pc_plus4),
    .instr_o    (ifid_instr)
  );

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Self-checking bench for fetch_pc_ifid: directed scenarios then randomized traffic against a transaction-level model.
module tb_fetch_pc_ifid;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic        flush;
  logic        stall;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;

  fetch_pc_ifid dut (
    .clk           (clk),
    .rst           (rst),
    .next_pc       (next_pc),
    .flush         (flush),
    .stall         (stall),
    .pc_plus4      (pc_plus4),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the fetch unit as "current pc, at most one parked instruction,
  // and possibly a doomed in-flight request with a pending redirect target".
  logic [31:0] m_pc;
  logic [31:0] m_park[$];
  bit          m_doomed;
  logic [31:0] m_redir;
  bit          m_v;
  logic [31:0] m_ipc, m_ipc4, m_instr;

  function automatic bit m_req();
    return !rst && (m_park.size() == 0);
  endfunction

  task automatic m_reset();
    m_pc = RPC; m_park.delete(); m_doomed = 0; m_redir = RPC;
    m_v = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP;
  endtask

  task automatic m_edge();
    bit          got;
    logic [31:0] data;
    logic [31:0] cur;
    got = 0; data = NOP; cur = m_pc;
    if (rst) begin
      m_reset();
      return;
    end
    if (m_park.size() != 0) begin
      if (flush) begin
        m_park.delete(); m_pc = next_pc;
      end else if (!stall) begin
        got = 1; data = m_park.pop_front(); m_pc = next_pc;
      end
    end else if (m_doomed) begin
      if (imem_ready) begin
        m_doomed = 0; m_pc = flush ? next_pc : m_redir;
      end else if (flush) m_redir = next_pc;
    end else if (imem_ready) begin
      if (flush) m_pc = next_pc;
      else if (stall) m_park.push_back(imem_rdata);
      else begin got = 1; data = imem_rdata; m_pc = next_pc; end
    end else if (flush) begin
      m_doomed = 1; m_redir = next_pc;
    end
    if (flush) begin
      m_v = 0; m_instr = NOP;
    end else if (stall) begin
      // hold
    end else if (got) begin
      m_v = 1; m_instr = data; m_ipc = cur; m_ipc4 = cur + 32'd4;
    end else begin
      m_v = 0; m_instr = NOP;
    end
  endtask

  // One cycle: drive inputs just after negedge, check all outputs, then advance model at posedge.
  task automatic step(input bit r, input bit rdy, input bit stl, input bit fl, input logic [31:0] tgt);
    rst        = r;
    imem_ready = rdy;
    stall      = stl;
    flush      = fl;
    next_pc    = fl ? tgt : m_pc + 32'd4;
    imem_rdata = rdy ? (m_pc ^ 32'hA5A5_0000) : $urandom;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    if (m_req()) chk("imem_addr", imem_addr, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
    chk("ifid_instr", ifid_instr, m_instr);
    if (m_v) begin
      chk("ifid_pc", ifid_pc, m_ipc);
      chk("ifid_pc_plus4", ifid_pc_plus4, m_ipc4);
    end
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; flush = 0; stall = 0; next_pc = 0; imem_ready = 0; imem_rdata = 0;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    // reset state, explicitly
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_ifid_pc4", ifid_pc_plus4, 32'h0);
    step(1, 1, 0, 0, 0);

    // streaming with ready tied high
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    // restart from reset, stall two cycles at pc=0x8
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    // redirect with ready high
    step(0, 1, 0, 1, 32'h100);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    // redirect while imem is slow
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h200);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    // flush and stall together
    step(0, 1, 1, 1, 32'h340);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // reset while a doomed request is outstanding
    step(0, 0, 0, 1, 32'h400);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    // PC wrap at the top of the address space
    step(0, 1, 0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r, rdy, stl, fl;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      stl = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 19) < 3);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(r, rdy, stl, fl, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
